// File: rtl/spi_master_arb_if.sv
`default_nettype none
// ============================================================================
// Module      : spi_master_arb_if
// Description : Requester-side handshake bundle for spi_master_arb. Carries
//               both request channels, their grants/completions and the
//               shared read-data/busy status.
// Revision    : 1.0 - initial release
// ============================================================================
interface spi_master_arb_if;
  logic       req0;
  logic       req1;
  logic       wr0;
  logic       wr1;
  logic [6:0] addr0;
  logic [6:0] addr1;
  logic [7:0] wdata0;
  logic [7:0] wdata1;
  logic       gnt0;
  logic       gnt1;
  logic       done0;
  logic       done1;
  logic [7:0] rdata;
  logic       busy;

  // Requester view: drives requests, observes grants and results
  modport master (
    output req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1,
    input  gnt0, gnt1, done0, done1, rdata, busy
  );

  // Arbiter view: observes requests, drives grants and results
  modport slave (
    input  req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1,
    output gnt0, gnt1, done0, done1, rdata, busy
  );
endinterface
`default_nettype wire

// File: rtl/spi_master_arb.sv
`default_nettype none
// ============================================================================
// Module      : spi_master_arb
// Description : Two-port arbiter plus SPI master. Grants one requester at a
//               time, shifts a 17-bit frame (dummy, R/W, addr[6:0],
//               data[7:0]) out on mosi, captures read data from miso and
//               emits 3 trailing sclk pulses with cs_n high so the slave can
//               commit writes.
//               Optional macro SPI_ARB_RR_EN: round-robin arbitration
//               instead of fixed channel-0 priority.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_master_arb #(
  parameter int CLK_DIV = 25000
) (
  input  wire              clk,
  input  wire              rst,
  spi_master_arb_if.slave  bus,
  output logic             sclk,
  output logic             cs_n,
  output logic             mosi,
  input  wire              miso
);

  localparam int         c_DIVW      = $clog2(CLK_DIV);
  localparam [c_DIVW-1:0] c_DIV_LAST = c_DIVW'(CLK_DIV - 1);
  // Half-period indices counted from the R0 half (SETUP is not counted)
  localparam [5:0]       c_HALF_R16  = 6'd32;
  localparam [5:0]       c_HALF_RX   = 6'd18;
  localparam [5:0]       c_HALF_LAST = 6'd39;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_SHIFT = 3'd2,
    S_TAIL  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [c_DIVW-1:0] r_div;
  logic [5:0]        r_half;
  logic [15:0]       r_sr;      // f1..f16; f0 is always 0 and driven at grant
  logic [7:0]        r_rx;
  logic              r_sel;     // 1 = channel 1 owns the link
  logic              r_is_rd;
  logic              w_tick;
  logic              w_any_req;
  logic              w_pick1;
  logic              w_wr;
  logic [6:0]        w_addr;
  logic [7:0]        w_wdata;
`ifdef SPI_ARB_RR_EN
  logic              r_last;    // channel granted most recently
`endif

  // Next state, arbitration decision and combinational status outputs
  always_comb begin
    w_state_nxt = r_state;
    w_tick      = (r_div == c_DIV_LAST);
    w_any_req   = bus.req0 | bus.req1;
`ifdef SPI_ARB_RR_EN
    w_pick1     = bus.req1 & (~bus.req0 | ~r_last);
`else
    w_pick1     = bus.req1 & ~bus.req0;
`endif
    w_wr        = w_pick1 ? bus.wr1    : bus.wr0;
    w_addr      = w_pick1 ? bus.addr1  : bus.addr0;
    w_wdata     = w_pick1 ? bus.wdata1 : bus.wdata0;
    bus.busy    = (r_state != S_IDLE);
    bus.done0   = (r_state == S_DONE) & ~r_sel;
    bus.done1   = (r_state == S_DONE) &  r_sel;
    case (r_state)
      S_IDLE:  if (w_any_req) w_state_nxt = S_SETUP;
      S_SETUP: if (w_tick) w_state_nxt = S_SHIFT;
      S_SHIFT: if (w_tick && sclk && r_half == c_HALF_R16) w_state_nxt = S_TAIL;
      S_TAIL:  if (w_tick && r_half == c_HALF_LAST) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Divider, serialiser, capture, grant and read-data registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div     <= '0;
      r_half    <= '0;
      r_sr      <= '0;
      r_rx      <= '0;
      r_sel     <= 1'b0;
      r_is_rd   <= 1'b0;
      sclk      <= 1'b0;
      cs_n      <= 1'b1;
      mosi      <= 1'b0;
      bus.gnt0  <= 1'b0;
      bus.gnt1  <= 1'b0;
      bus.rdata <= 8'h00;
`ifdef SPI_ARB_RR_EN
      r_last    <= 1'b1;
`endif
    end else begin
      if (r_state == S_IDLE || r_state == S_DONE || w_tick) r_div <= '0;
      else                                                   r_div <= r_div + 1'b1;

      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_sel    <= w_pick1;
            r_is_rd  <= ~w_wr;
            r_sr     <= {~w_wr, w_addr, (w_wr ? w_wdata : 8'h00)};
            bus.gnt0 <= ~w_pick1;
            bus.gnt1 <= w_pick1;
            cs_n     <= 1'b0;
            mosi     <= 1'b0;
            r_half   <= '0;
          end
        end
        S_SETUP: begin
          if (w_tick) sclk <= 1'b1;
        end
        S_SHIFT: begin
          if (w_tick) begin
            r_half <= r_half + 6'd1;
            if (sclk) begin
              // Falling edge Fk, k = r_half/2: advance mosi, sample miso
              sclk <= 1'b0;
              if (r_half >= c_HALF_RX) r_rx <= {r_rx[6:0], miso};
              if (r_half == c_HALF_R16) begin
                cs_n <= 1'b1;
                mosi <= 1'b0;
              end else begin
                mosi <= r_sr[15];
                r_sr <= {r_sr[14:0], 1'b0};
              end
            end else begin
              sclk <= 1'b1;
            end
          end
        end
        S_TAIL: begin
          if (w_tick) begin
            r_half <= r_half + 6'd1;
            if (r_half == c_HALF_LAST) begin
              // Load read data on entry to DONE so it is valid with done
              if (r_is_rd) bus.rdata <= r_rx;
            end else begin
              sclk <= ~sclk;
            end
          end
        end
        S_DONE: begin
          bus.gnt0 <= 1'b0;
          bus.gnt1 <= 1'b0;
`ifdef SPI_ARB_RR_EN
          r_last   <= r_sel;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_master_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_master_arb
// Description : Directed self-checking bench for spi_master_arb with a small
//               behavioural model of the 4-register SPI slave.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_master_arb;

  localparam int c_CLK_DIV = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sclk, cs_n, mosi, miso;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;

  spi_master_arb_if bus ();

  spi_master_arb #(.CLK_DIV(c_CLK_DIV)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .sclk (sclk),
    .cs_n (cs_n),
    .mosi (mosi),
    .miso (miso)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- slave model and monitors (evaluated on negedge) -------
  logic [7:0]  s_reg [4];
  logic [16:0] s_bits;
  logic [16:0] s_frame;
  logic [7:0]  s_rd;
  logic        s_rw;
  int          s_cnt;
  logic        sclk_q, cs_q, g0_q, g1_q;
  int          n_done0, n_done1;
  int          glog [$];

  always @(negedge clk) begin
    sclk_q <= sclk;
    cs_q   <= cs_n;
    g0_q   <= bus.gnt0;
    g1_q   <= bus.gnt1;
    if (bus.gnt0 && !g0_q) glog.push_back(0);
    if (bus.gnt1 && !g1_q) glog.push_back(1);
    if (bus.done0) n_done0 <= n_done0 + 1;
    if (bus.done1) n_done1 <= n_done1 + 1;
    if (rst) begin
      for (int i = 0; i < 4; i++) s_reg[i] <= 8'h00;
      s_cnt  <= 0;
      s_bits <= '0;
      s_rd   <= 8'h00;
      s_rw   <= 1'b0;
    end else begin
      if (!cs_n && cs_q) s_cnt <= 0;
      if (!cs_n && sclk && !sclk_q) begin
        s_bits <= {s_bits[15:0], mosi};
        s_cnt  <= s_cnt + 1;
        if (s_cnt == 1) s_rw <= mosi;
        if (s_cnt == 8)
          s_rd <= ({s_bits[5:0], mosi} < 7'd4) ? s_reg[{s_bits[0], mosi}] : 8'h00;
      end
      if (cs_n && !cs_q && s_cnt == 17) begin
        s_frame <= s_bits;
        if (!s_bits[15] && s_bits[14:8] < 7'd4) s_reg[s_bits[9:8]] <= s_bits[7:0];
        s_cnt <= 0;
      end
    end
  end

  // Slave drives read data MSB first for master samples at F9..F16
  always_comb begin
    miso = 1'b0;
    if (s_rw && s_cnt >= 10 && s_cnt <= 17) miso = s_rd[3'(17 - s_cnt)];
  end

  initial begin
    s_frame = '0;
    sclk_q = 0; cs_q = 1; g0_q = 0; g1_q = 0;
    n_done0 = 0; n_done1 = 0;
  end

  // ---------------- checking helpers ---------------------------------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic start(input int ch, input logic wr, input logic [6:0] a, input logic [7:0] d);
    if (ch == 0) begin
      bus.wr0 = wr; bus.addr0 = a; bus.wdata0 = d; bus.req0 = 1'b1;
    end else begin
      bus.wr1 = wr; bus.addr1 = a; bus.wdata1 = d; bus.req1 = 1'b1;
    end
  endtask

  // Waits on negedges for the channel's done pulse; returns its cycle or -1
  task automatic wait_done(input int ch, output int at);
    at = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if ((ch == 0) ? bus.done0 : bus.done1) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_edges(input int n);
    int i;
    for (i = 0; i < 400 && s_cnt < n; i++) @(negedge clk);
    if (s_cnt < n) chk("edge_timeout", 32'(s_cnt), 32'(n));
  endtask

  // ---------------- directed sequence --------------------------------------
  initial begin
    int t0, td, base;
    bus.req0 = 0; bus.req1 = 0; bus.wr0 = 0; bus.wr1 = 0;
    bus.addr0 = 0; bus.addr1 = 0; bus.wdata0 = 0; bus.wdata1 = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst_sclk", 32'(sclk), 32'd0);
    chk("rst_cs_n", 32'(cs_n), 32'd1);
    chk("rst_mosi", 32'(mosi), 32'd0);
    chk("rst_busy_gnt_done", {28'd0, bus.busy, bus.gnt0, bus.gnt1, bus.done0 | bus.done1}, 32'd0);
    chk("rst_rdata", 32'(bus.rdata), 32'h00);

    // Write 0xA5 to reg2 via channel 0
    start(0, 1'b1, 7'd2, 8'hA5);
    t0 = cyc;
    @(negedge clk);
    chk("wr_gnt_latency", {30'd0, bus.gnt0, bus.gnt1}, 32'b10);
    chk("wr_cs_busy", {30'd0, cs_n, bus.busy}, 32'b01);
    wait_done(0, td);
    bus.req0 = 1'b0;
    chk("wr_done_cycle", 32'(td - t0), 32'd83);
    chk("wr_mosi_frame", 32'(s_frame), {15'd0, 1'b0, 1'b0, 7'h02, 8'hA5});
    chk("wr_reg2_before_done", 32'(s_reg[2]), 32'hA5);
    chk("wr_cs_at_done", 32'(cs_n), 32'd1);

    // Read back reg2 via channel 1
    @(negedge clk);
    start(1, 1'b0, 7'd2, 8'h00);
    wait_done(1, td);
    bus.req1 = 1'b0;
    chk("rd_rdata", 32'(bus.rdata), 32'hA5);
    chk("rd_mosi_frame", 32'(s_frame), {15'd0, 1'b0, 1'b1, 7'h02, 8'h00});
    chk("rd_regs_unchanged", {s_reg[3], s_reg[2], s_reg[1], s_reg[0]}, 32'h00A5_0000);
    @(negedge clk);
    chk("rdata_hold", 32'(bus.rdata), 32'hA5);

    // Both requests together in IDLE: channel 0 then channel 1
    glog.delete();
    start(0, 1'b1, 7'd0, 8'h11);
    start(1, 1'b1, 7'd1, 8'h22);
    wait_done(0, td);
    bus.req0 = 1'b0;
    wait_done(1, td);
    bus.req1 = 1'b0;
    chk("tie_grant_count", 32'(glog.size()), 32'd2);
    if (glog.size() >= 2) begin
      chk("tie_first", 32'(glog[0]), 32'd0);
      chk("tie_second", 32'(glog[1]), 32'd1);
    end
    chk("tie_regs", {s_reg[1], s_reg[0]}, 32'h2211);

    // Both held for four transactions
    @(negedge clk);
    glog.delete();
    base = n_done0 + n_done1;
    start(0, 1'b1, 7'd0, 8'h11);
    start(1, 1'b1, 7'd1, 8'h22);
    for (int i = 0; i < 800 && (n_done0 + n_done1 + ((bus.done0 | bus.done1) ? 1 : 0)) < base + 4; i++)
      @(negedge clk);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    repeat (4) @(negedge clk);
    chk("held_grants", 32'(glog.size()), 32'd4);
    if (glog.size() >= 4) begin
`ifdef SPI_ARB_RR_EN
      chk("held_order", {glog[0][7:0], glog[1][7:0], glog[2][7:0], glog[3][7:0]}, 32'h00010001);
`else
      chk("held_order", {glog[0][7:0], glog[1][7:0], glog[2][7:0], glog[3][7:0]}, 32'h00000000);
`endif
    end
    chk("held_idle", 32'(bus.busy), 32'd0);

    // Out-of-range write
    base = n_done1;
    start(1, 1'b1, 7'h10, 8'hFF);
    wait_done(1, td);
    bus.req1 = 1'b0;
    @(negedge clk);
    chk("oor_done", 32'(n_done1 - base), 32'd1);
    chk("oor_regs", {s_reg[3], s_reg[2], s_reg[1], s_reg[0]}, 32'h00A5_2211);

    // Reset at R10 of a write to reg1
    base = n_done0;
    start(0, 1'b1, 7'd1, 8'h3C);
    wait_edges(11);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_cs_sclk", {30'd0, cs_n, sclk}, 32'b10);
    chk("midrst_busy_gnt", {29'd0, bus.busy, bus.gnt0, bus.done0}, 32'd0);
    rst = 1'b0;
    bus.req0 = 1'b0;
    repeat (20) @(negedge clk);
    chk("midrst_no_done", 32'(n_done0 - base), 32'd0);
    chk("midrst_reg1", 32'(s_reg[1]), 32'h00);
    start(0, 1'b1, 7'd1, 8'h3C);
    wait_done(0, td);
    bus.req0 = 1'b0;
    chk("after_rst_write", 32'(s_reg[1]), 32'h3C);

    // Request dropped at R4 still completes with exactly one done
    @(negedge clk);
    base = n_done0;
    start(0, 1'b1, 7'd3, 8'h5A);
    wait_edges(5);
    bus.req0 = 1'b0;
    wait_done(0, td);
    repeat (10) @(negedge clk);
    chk("drop_one_done", 32'(n_done0 - base), 32'd1);
    chk("drop_idle", 32'(bus.busy), 32'd0);
    chk("drop_reg3", 32'(s_reg[3]), 32'h5A);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
